// File: rtl/sprite_shadow_regs.sv
// sprite_shadow_regs
// Double-buffered register bank sitting between the Avalon-MM slave port and
// the sprite/score renderer. The CPU writes shadow registers at any time; the
// whole bank is copied into the active registers in one cycle at the start of
// vertical blanking, so the renderer never sees a half-updated frame.
// A frame counter and a status word let software pace its game loop.
`timescale 1ns/1ps

module sprite_shadow_regs #(
  parameter int NUM_REGS = 16,
  parameter int DATA_W   = 10,
  parameter int VACTIVE  = 480
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         chipselect,
  input  logic                         write,
  input  logic                         read,
  input  logic [8:0]                   address,
  input  logic [31:0]                  writedata,
  output logic [31:0]                  readdata,
  input  logic [9:0]                   vcount,
  output logic [NUM_REGS*DATA_W-1:0]   active_regs,
  output logic                         commit_pulse,
  output logic [15:0]                  frame_count
);

  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  localparam logic [8:0] ADDR_CONTROL = 9'h100;
  localparam logic [8:0] ADDR_STATUS  = 9'h101;
  localparam logic [8:0] ADDR_FRAME   = 9'h102;
  localparam logic [8:0] SHADOW_LIMIT = 9'(NUM_REGS);
  localparam logic [9:0] VACTIVE_LINE = 10'(VACTIVE);

  // Commit sequencing states
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ARMED  = 2'd1;
  localparam logic [1:0] ST_COMMIT = 2'd2;

  // ---------------------------------------------------------------------------
  // Bus decode
  // ---------------------------------------------------------------------------
  logic             wr_en;
  logic             rd_en;
  logic             shadow_hit;
  logic             shadow_wr;
  logic             ctrl_wr;
  logic             arm_wr;
  logic [IDX_W-1:0] shadow_idx;

  assign wr_en      = chipselect & write;
  assign rd_en      = chipselect & read;
  assign shadow_hit = (address < SHADOW_LIMIT);
  assign shadow_wr  = wr_en & shadow_hit;
  assign ctrl_wr    = wr_en & (address == ADDR_CONTROL);
  assign arm_wr     = ctrl_wr & writedata[0];
  assign shadow_idx = address[IDX_W-1:0];

  // Upper write-data bits have no storage behind them.
  logic unused_wdata_bits;
  assign unused_wdata_bits = ^writedata[31:DATA_W];

  // ---------------------------------------------------------------------------
  // State and control registers
  // ---------------------------------------------------------------------------
  logic [1:0]  state_q, state_d;
  logic        armed_q, armed_d;
  logic        dirty_q, dirty_d;
  logic        auto_mode_q, auto_mode_d;
  logic [15:0] frame_count_q, frame_count_d;
  logic [9:0]  vcount_prev_q;
  logic [31:0] readdata_q, readdata_d;
  logic        vblank_edge;
  logic        commit_now;
  logic        pending;

  // First cycle of the commit line: current line is VACTIVE, previous was not.
  assign vblank_edge = (vcount == VACTIVE_LINE) && (vcount_prev_q != VACTIVE_LINE);
  assign commit_now  = (state_q == ST_COMMIT);
  assign pending     = armed_q | (auto_mode_q & dirty_q);

  // ---------------------------------------------------------------------------
  // Shadow and active register bank, flattened for the read mux and renderer
  // ---------------------------------------------------------------------------
  logic [NUM_REGS*DATA_W-1:0] shadow_flat;
  logic [NUM_REGS*DATA_W-1:0] active_flat;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_regs
      logic [DATA_W-1:0] shadow_q, shadow_d;
      logic [DATA_W-1:0] active_q, active_d;

      // A shadow write targets exactly one register; the active copy only
      // moves during the commit cycle and samples the pre-write shadow value.
      assign shadow_d = (shadow_wr && (shadow_idx == IDX_W'(gi)))
                        ? writedata[DATA_W-1:0] : shadow_q;
      assign active_d = commit_now ? shadow_q : active_q;

      // Per-register shadow/active storage
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          shadow_q <= '0;
          active_q <= '0;
        end else begin
          shadow_q <= shadow_d;
          active_q <= active_d;
        end
      end

      assign shadow_flat[gi*DATA_W +: DATA_W] = shadow_q;
      assign active_flat[gi*DATA_W +: DATA_W] = active_q;
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Commit FSM next state
  // ---------------------------------------------------------------------------
  // An arm request in IDLE wins over a coincident auto commit, so an arm that
  // lands on the vblank edge defers the commit to the following frame.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (arm_wr) begin
          state_d = ST_ARMED;
        end else if (vblank_edge && auto_mode_q && dirty_q) begin
          state_d = ST_COMMIT;
        end
      end
      ST_ARMED: begin
        if (vblank_edge) begin
          state_d = ST_COMMIT;
        end
      end
      ST_COMMIT: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Control flags, frame counter and read data next values
  always_comb begin
    armed_d       = (state_d == ST_ARMED);
    // A shadow write in the commit cycle keeps dirty set: its value was not
    // part of this commit.
    dirty_d       = shadow_wr | (dirty_q & ~commit_now);
    auto_mode_d   = ctrl_wr ? writedata[1] : auto_mode_q;
    frame_count_d = vblank_edge ? (frame_count_q + 16'd1) : frame_count_q;

    readdata_d = readdata_q;
    if (rd_en) begin
      readdata_d = '0;
      if (shadow_hit) begin
        readdata_d = 32'(shadow_flat[shadow_idx*DATA_W +: DATA_W]);
      end else if (address == ADDR_STATUS) begin
        readdata_d = {30'b0, auto_mode_q, pending};
      end else if (address == ADDR_FRAME) begin
        readdata_d = {16'b0, frame_count_q};
      end
    end
  end

  // Control and status state registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      armed_q       <= 1'b0;
      dirty_q       <= 1'b0;
      auto_mode_q   <= 1'b0;
      frame_count_q <= 16'd0;
      vcount_prev_q <= 10'd0;
      readdata_q    <= 32'd0;
    end else begin
      state_q       <= state_d;
      armed_q       <= armed_d;
      dirty_q       <= dirty_d;
      auto_mode_q   <= auto_mode_d;
      frame_count_q <= frame_count_d;
      vcount_prev_q <= vcount;
      readdata_q    <= readdata_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign active_regs  = active_flat;
  assign commit_pulse = commit_now;
  assign frame_count  = frame_count_q;
  assign readdata     = readdata_q;

endmodule

// File: tb/tb_sprite_shadow_regs.sv
// Directed testbench for sprite_shadow_regs: a register-map vector table plus
// hand-written frame sequences for commit timing and collision cases.
`timescale 1ns/1ps

module tb_sprite_shadow_regs;

  localparam int NUM_REGS = 16;
  localparam int DATA_W   = 10;

  logic                       clk = 1'b0;
  logic                       reset_n;
  logic                       chipselect;
  logic                       write;
  logic                       read;
  logic [8:0]                 address;
  logic [31:0]                writedata;
  logic [31:0]                readdata;
  logic [9:0]                 vcount;
  logic [NUM_REGS*DATA_W-1:0] active_regs;
  logic                       commit_pulse;
  logic [15:0]                frame_count;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sprite_shadow_regs #(
    .NUM_REGS(NUM_REGS),
    .DATA_W  (DATA_W),
    .VACTIVE (480)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .chipselect  (chipselect),
    .write       (write),
    .read        (read),
    .address     (address),
    .writedata   (writedata),
    .readdata    (readdata),
    .vcount      (vcount),
    .active_regs (active_regs),
    .commit_pulse(commit_pulse),
    .frame_count (frame_count)
  );

  typedef struct {
    bit          do_wr;
    logic [8:0]  wr_addr;
    logic [31:0] wr_data;
    logic [8:0]  rd_addr;
    logic [31:0] exp;
  } vec_t;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end else begin
      $display("ok   %s value=0x%08h", name, act);
    end
  endtask

  function automatic logic [31:0] act_reg(input int i);
    return 32'(active_regs[i*DATA_W +: DATA_W]);
  endfunction

  task automatic bus_write(input logic [8:0] a, input logic [31:0] d);
    chipselect = 1'b1;
    write      = 1'b1;
    address    = a;
    writedata  = d;
    tick();
    chipselect = 1'b0;
    write      = 1'b0;
  endtask

  task automatic bus_read(input logic [8:0] a, output logic [31:0] d);
    chipselect = 1'b1;
    read       = 1'b1;
    address    = a;
    tick();
    chipselect = 1'b0;
    read       = 1'b0;
    d          = readdata;
  endtask

  task automatic check_read(input string name, input logic [8:0] a, input logic [31:0] exp);
    logic [31:0] d;
    bus_read(a, d);
    check(name, d, exp);
  endtask

  // Drives one 479 -> 480 line transition and counts commit pulses.
  task automatic do_vblank(output int pulses);
    pulses = 0;
    vcount = 10'd479;
    tick();
    vcount = 10'd480;
    repeat (4) begin
      tick();
      if (commit_pulse) pulses++;
    end
    vcount = 10'd0;
    tick();
  endtask

  vec_t vecs[13];

  initial begin
    int p;

    vecs[0]  = '{1'b0, 9'h000, 32'h0000_0000, 9'h101, 32'h0000_0000};
    vecs[1]  = '{1'b0, 9'h000, 32'h0000_0000, 9'h102, 32'h0000_0002};
    vecs[2]  = '{1'b1, 9'h003, 32'h0000_03FF, 9'h003, 32'h0000_03FF};
    vecs[3]  = '{1'b1, 9'h004, 32'hFFFF_F123, 9'h004, 32'h0000_0123};
    vecs[4]  = '{1'b1, 9'h00F, 32'h0000_0155, 9'h00F, 32'h0000_0155};
    vecs[5]  = '{1'b1, 9'h150, 32'hFFFF_FFFF, 9'h150, 32'h0000_0000};
    vecs[6]  = '{1'b0, 9'h000, 32'h0000_0000, 9'h003, 32'h0000_03FF};
    vecs[7]  = '{1'b0, 9'h000, 32'h0000_0000, 9'h100, 32'h0000_0000};
    vecs[8]  = '{1'b1, 9'h100, 32'h0000_0002, 9'h101, 32'h0000_0003};
    vecs[9]  = '{1'b1, 9'h100, 32'h0000_0000, 9'h101, 32'h0000_0000};
    vecs[10] = '{1'b0, 9'h000, 32'h0000_0000, 9'h00E, 32'h0000_0000};
    vecs[11] = '{1'b1, 9'h010, 32'h0000_0077, 9'h010, 32'h0000_0000};
    vecs[12] = '{1'b0, 9'h000, 32'h0000_0000, 9'h000, 32'h0000_0000};

    reset_n    = 1'b0;
    chipselect = 1'b0;
    write      = 1'b0;
    read       = 1'b0;
    address    = '0;
    writedata  = '0;
    vcount     = 10'd0;
    repeat (3) tick();
    reset_n = 1'b1;
    tick();

    // Reset state
    check("rst_commit_pulse", 32'(commit_pulse), 32'd0);
    check("rst_active_any", 32'(|active_regs), 32'd0);
    check("rst_frame_count", 32'(frame_count), 32'd0);
    check("rst_readdata", readdata, 32'd0);

    // Two idle frames: counter advances, nothing commits
    do_vblank(p);
    check("idle1_pulses", 32'(p), 32'd0);
    do_vblank(p);
    check("idle2_pulses", 32'(p), 32'd0);
    check("idle_active_any", 32'(|active_regs), 32'd0);
    check("idle_frame_count", 32'(frame_count), 32'd2);

    // Register map vectors
    for (int i = 0; i < 13; i++) begin
      if (vecs[i].do_wr) bus_write(vecs[i].wr_addr, vecs[i].wr_data);
      check_read($sformatf("vec%0d_rd_%03h", i, vecs[i].rd_addr), vecs[i].rd_addr, vecs[i].exp);
    end

    // Auto mode cleared while dirty: no commit, dirty kept
    do_vblank(p);
    check("noauto_pulses", 32'(p), 32'd0);
    check("noauto_active_r3", act_reg(3), 32'd0);

    // Manual arm
    vcount = 10'd100;
    bus_write(9'h000, 32'h064);
    bus_write(9'h001, 32'h0C8);
    bus_write(9'h100, 32'h1);
    check_read("man_status_armed", 9'h101, 32'h1);
    vcount = 10'd479;
    tick();
    check("man_active_r0_pre", act_reg(0), 32'd0);
    do_vblank(p);
    check("man_pulses", 32'(p), 32'd1);
    check("man_active_r0", act_reg(0), 32'd100);
    check("man_active_r1", act_reg(1), 32'd200);
    check("man_active_r3", act_reg(3), 32'h3FF);
    check("man_active_r4", act_reg(4), 32'h123);
    check_read("man_status_after", 9'h101, 32'h0);
    check("man_frame_count", 32'(frame_count), 32'd4);

    // Auto mode
    bus_write(9'h100, 32'h2);
    check_read("auto_status_clean", 9'h101, 32'h2);
    bus_write(9'h006, 32'h1F4);
    check_read("auto_status_dirty", 9'h101, 32'h3);
    do_vblank(p);
    check("auto_pulses", 32'(p), 32'd1);
    check("auto_active_r6", act_reg(6), 32'd500);
    do_vblank(p);
    check("auto_idle_pulses", 32'(p), 32'd0);
    check("auto_frame_count", 32'(frame_count), 32'd6);

    // Shadow write landing on the commit cycle
    bus_write(9'h002, 32'h011);
    vcount = 10'd479;
    tick();
    vcount = 10'd480;
    tick();
    check("coll_pulse_high", 32'(commit_pulse), 32'd1);
    bus_write(9'h002, 32'h0AA);
    check("coll_pulse_low", 32'(commit_pulse), 32'd0);
    check("coll_active_r2_old", act_reg(2), 32'h011);
    vcount = 10'd0;
    tick();
    check_read("coll_status_dirty", 9'h101, 32'h3);
    do_vblank(p);
    check("coll_next_pulses", 32'(p), 32'd1);
    check("coll_active_r2_new", act_reg(2), 32'h0AA);

    // Arm write coincident with the vblank edge
    bus_write(9'h100, 32'h0);
    bus_write(9'h005, 32'h02A);
    vcount = 10'd479;
    tick();
    vcount = 10'd480;
    bus_write(9'h100, 32'h1);
    p = 0;
    repeat (3) begin
      tick();
      if (commit_pulse) p++;
    end
    vcount = 10'd0;
    tick();
    check("armedge_pulses", 32'(p), 32'd0);
    check_read("armedge_status", 9'h101, 32'h1);
    check("armedge_active_r5_old", act_reg(5), 32'd0);
    do_vblank(p);
    check("armedge_next_pulses", 32'(p), 32'd1);
    check("armedge_active_r5_new", act_reg(5), 32'h02A);
    check("armedge_frame_count", 32'(frame_count), 32'd10);

    // Frame counter wrap
    force dut.frame_count_q = 16'hFFFF;
    tick();
    release dut.frame_count_q;
    tick();
    check("wrap_preload", 32'(frame_count), 32'h0000_FFFF);
    do_vblank(p);
    check("wrap_frame_count", 32'(frame_count), 32'd0);

    // Reset asserted in the middle of a commit cycle
    bus_write(9'h007, 32'h003);
    bus_write(9'h100, 32'h1);
    vcount = 10'd479;
    tick();
    vcount = 10'd480;
    tick();
    check("rstmid_pulse_high", 32'(commit_pulse), 32'd1);
    reset_n = 1'b0;
    #1;
    check("rstmid_commit_pulse", 32'(commit_pulse), 32'd0);
    check("rstmid_active_any", 32'(|active_regs), 32'd0);
    check("rstmid_frame_count", 32'(frame_count), 32'd0);
    check("rstmid_readdata", readdata, 32'd0);
    tick();
    tick();
    vcount  = 10'd0;
    reset_n = 1'b1;
    p = 0;
    repeat (3) begin
      tick();
      if (commit_pulse) p++;
    end
    check("rstmid_after_pulses", 32'(p), 32'd0);
    check("rstmid_after_active_any", 32'(|active_regs), 32'd0);
    check_read("rstmid_after_r7", 9'h007, 32'h0);
    check_read("rstmid_after_status", 9'h101, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sprite_shadow_regs.md
Name: sprite_shadow_regs

Overview:
- Double-buffered register bank between the Avalon-MM slave port and the sprite/score pixel renderer.
- CPU writes (sprite x/y, score, score position) land in shadow registers.
- Shadow contents are copied into the active registers, which drive the renderer, in a single cycle at the start of vertical blanking. This prevents mid-frame tearing.
- Also provides a frame counter and status readback, so software can pace game updates to the display.

Parameters:
- NUM_REGS, 16, number of shadow/active register pairs (addresses 0..NUM_REGS-1).
- DATA_W, 10, width of each register; writedata[DATA_W-1:0] is stored.
- VACTIVE, 480, first non-visible line; commit line.

Ports:
- clk  in  1  system clock (50 MHz, same as the pixel counters).
- reset_n  in  1  asynchronous active-low reset.
- chipselect  in  1  slave select.
- write  in  1  write strobe, qualified by chipselect.
- read  in  1  read strobe, qualified by chipselect.
- address  in  9  word address.
- writedata  in  32  write data.
- readdata  out  32  registered read data.
- vcount  in  10  current line from the VGA timing counters.
- active_regs  out  NUM_REGS*DATA_W  flattened active registers; reg i is at bits [i*DATA_W +: DATA_W].
- commit_pulse  out  1  high for exactly the one cycle in which active_regs update.
- frame_count  out  16  count of vblank starts.

Behaviour:
- Reset (reset_n low, asynchronous): all shadow regs, active_regs, readdata, frame_count, commit_pulse, dirty, armed and auto_mode go to 0. State goes to IDLE.
- Address map:
  - 0..NUM_REGS-1: shadow regs, read/write.
  - 0x100 CONTROL (write): bit0 = arm, bit1 = auto_mode.
  - 0x101 STATUS (read): {30'b0, auto_mode, pending}; pending = armed | (auto_mode & dirty).
  - 0x102 FRAME (read): {16'b0, frame_count}.
  - Other addresses: writes ignored, reads return 0.
- Write: on a cycle with chipselect & write, the target register updates at the next edge. Any shadow write sets dirty.
- Read: readdata is valid on the cycle after chipselect & read (latency 1). It holds its value until the next read.
- vblank_edge: a one-cycle internal pulse, produced from a one-cycle-delayed copy of vcount. It fires on the first cycle where vcount == VACTIVE and the previous vcount != VACTIVE.
- FSM: IDLE, ARMED, COMMIT.
  - IDLE -> ARMED: CONTROL write with bit0 = 1.
  - IDLE -> COMMIT: vblank_edge & auto_mode & dirty.
  - ARMED -> COMMIT: vblank_edge.
  - ARMED -> ARMED: a repeated arm is a no-op.
  - COMMIT -> IDLE: always, after 1 cycle.
- In the COMMIT cycle:
  - All active regs <= shadow regs in the same edge; commit_pulse = 1.
  - dirty and armed are cleared.
  - Exception: if a shadow write occurs in this cycle, dirty stays 1.
- Simultaneous events:
  - Shadow write during the COMMIT cycle: the committed value is the pre-write shadow. The new value waits for the next commit.
  - Arm write in the same cycle as vblank_edge while in IDLE: no commit this frame. The FSM enters ARMED and commits at the next frame.
  - Clearing auto_mode while dirty: no auto commit happens; dirty is retained.
- frame_count increments on every vblank_edge regardless of state, and wraps 0xFFFF -> 0x0000.
- Reset asserted mid-commit: every register returns to its reset value. No partial copy is visible after reset release.
- Width rule: shadow stores writedata[DATA_W-1:0]. Reads zero-extend to 32 bits.

Test Plan:
- Reset then idle 2 frames -> active_regs = 0, frame_count = 2, commit_pulse never high, readdata = 0.
- Manual: write reg0 = 0x064, reg1 = 0x0C8, then CONTROL = 0x1 at vcount = 100 -> STATUS reads 0x1. active_regs unchanged until the vcount 479->480 transition. Then exactly one commit_pulse; reg0 = 100, reg1 = 200; STATUS reads 0x0.
- Auto: CONTROL = 0x2, write reg6 = 0x1F4 -> commit at the next vblank with reg6 = 500. The following vblank with no writes -> no commit_pulse.
- Collision: in auto mode, write reg2 = 0x0AA on the COMMIT cycle -> active reg2 keeps its old value. The next frame commits 0x0AA.
- Arm coincident with vblank_edge -> no commit this frame; commit at the next frame. Reading address 0x150 -> 0; writing 0x150 -> no state change.
- Preload frame_count via 65536 vblanks (or force) -> wraps to 0. Assert reset_n low during a COMMIT cycle -> all outputs 0 immediately, FSM in IDLE.
